alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one `ALU` instance between `N_REQ` requesters, typically the per-core execute stages of the multicore build.
- Each requester issues an operation (A, B, alu_op) over a valid/ready request channel.
- A round-robin arbiter grants one requester at a time, and the block sequences the operation through a registered ALU stage.
- The result returns on that requester's own valid/ready response channel.
- One operation is in flight at a time; the block sits between the cores and the shared ALU datapath.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (2..8).
- `W`, default 32: operand/result width; must be 32 to match `ALU`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  N_REQ: request valid per requester.
- `req_ready`  out  N_REQ: request accepted this cycle (one-hot or zero).
- `req_a`  in  N_REQ x W: operand A per requester.
- `req_b`  in  N_REQ x W: operand B per requester.
- `req_op`  in  N_REQ x 4: alu_op per requester.
- `rsp_valid`  out  N_REQ: result valid (one-hot or zero).
- `rsp_ready`  in  N_REQ: requester takes result.
- `rsp_data`  out  W: result, shared by all requesters; qualified by `rsp_valid`.
- `rsp_err`  out  1: illegal-opcode flag, qualified by `rsp_valid`. Tied 0 unless `ALU_SHARE_OPCHECK_EN` is defined.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, pick grant g round-robin. The search starts at `last_grant+1` and wraps modulo N_REQ.
  - Drive `req_ready[g]=1` combinationally in the same cycle.
  - On the edge: latch `req_a[g]`, `req_b[g]` and `req_op[g]` into operand registers, set `cur_id=g`, set `last_grant=g`, and go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE; all `req_ready` bits are 0.
- **EXEC:**
  - `ALU` evaluates the latched operands combinationally.
  - On the edge: register C into `rsp_data`, compute `rsp_err`, and go to RESP.
- **RESP:**
  - Drive `rsp_valid[cur_id]=1`; `rsp_data` and `rsp_err` are held stable.
  - On the edge where `rsp_ready[cur_id]` is high, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is 0 in EXEC and RESP. Once `req_valid` is asserted, requesters hold it and its payload until `req_ready` is seen.
- ALU arithmetic, all unsigned 32-bit:
  - Result wraps modulo 2^32.
  - Op 0: add. Op 1: shift left. Ops 2 and 3: unsigned less-than, result 1 or 0.
  - Op 4: xor. Op 5: logical shift right. Op 6: logical shift right, identical to op 5 because operands are unsigned. Op 7: or. Op 8: and. Op 9: subtract.
  - Ops 10..15: result 0.
  - A shift amount B of 32 or more yields 0.
- Reset values: FSM = IDLE, `last_grant = N_REQ-1` (requester 0 wins first), `cur_id = 0`, operand registers = 0, `rsp_data = 0`, `rsp_err = 0`, all `req_ready` = 0, all `rsp_valid` = 0, `busy = 0`.
- Asserting `rst_n` low mid-operation drops the transaction; no response is produced.

## Timing
- Acceptance edge E0 moves IDLE to EXEC. Edge E1 moves EXEC to RESP. `rsp_valid` is high from the cycle after E1.
- Latency: 2 cycles from the acceptance cycle to the first `rsp_valid` cycle.
- Minimum issue interval: 3 cycles, with `rsp_ready` already high. The next grant can be issued in the IDLE cycle right after the response edge.
- Simultaneous requests are resolved purely by round-robin. A requester that holds `req_valid` waits at most N_REQ-1 other grants.
- Backpressure: `rsp_ready` low holds RESP indefinitely; `busy` stays 1.

## Configuration
- Macro: `ALU_SHARE_OPCHECK_EN`.
- Defined: `rsp_err=1` for `req_op` ≥ 10, with `rsp_data=0`. The error is also counted in an 8-bit saturating register `err_cnt`, which resets to 0 and is readable through the hierarchy.
- Not defined: `rsp_err` is constant 0, `err_cnt` is absent, and ops 10..15 silently return 0.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_e` enum (ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, SRA=6, OR=7, AND=8, SUB=9).
  - `ALU_OP_MAX = 9`.
  - `arb_state_e` enum (IDLE, EXEC, RESP).
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index.
- `ALU` is instantiated once, unchanged.

## Test plan
- **Single request:** requester 0, A=5, B=3, op=0, `rsp_ready=1` → `req_ready[0]` in the request cycle, `rsp_valid[0]` two cycles later, `rsp_data=8`.
- **Contention:** both requesters valid from reset, op=9, A=10, B=3 → grants 0, 1, 0, 1 alternate; each result is 7 and is delivered to the matching `rsp_valid` bit.
- **Backpressure:** `rsp_ready` held low for 5 cycles after `rsp_valid` → `rsp_data` stable, `busy=1`, `req_ready` all 0; release → IDLE the next cycle.
- **Arithmetic edges:**
  - A=0xFFFFFFFF, B=1, op=0 → 0.
  - A=1, B=32, op=1 → 0.
  - A=0x80000000, B=4, op=6 → 0x08000000.
  - A=0xFFFFFFFF, B=1, op=3 → 0.
- **Reset mid-EXEC:** drop `rst_n` during EXEC → all outputs at reset values immediately, no response; the next request is granted to requester 0.
- **Illegal opcode:** op=12 → with `ALU_SHARE_OPCHECK_EN`, `rsp_data=0`, `rsp_err=1`, `err_cnt` increments; without it, `rsp_data=0`, `rsp_err=0`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU sharing block: opcode encoding, arbiter FSM states.
// Optional feature macro used by the block: ALU_SHARE_OPCHECK_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SLL  = 4'd1,
        SLT  = 4'd2,
        SLTU = 4'd3,
        XOR  = 4'd4,
        SRL  = 4'd5,
        SRA  = 4'd6,
        OR   = 4'd7,
        AND  = 4'd8,
        SUB  = 4'd9
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Opcodes above ALU_OP_MAX have no defined operation.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit unsigned ALU; unknown opcodes return zero.
module ALU
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  alu_op,
    output logic [31:0] C
);

    logic shift_oob;

    // Shifts by 32 or more clear the result.
    always_comb begin
        shift_oob = (B > 32'd31);
        C         = '0;
        case (alu_op_e'(alu_op))
            ADD:       C = A + B;
            SLL:       C = shift_oob ? '0 : (A << B[4:0]);
            SLT, SLTU: C = {31'd0, (A < B)};
            XOR:       C = A ^ B;
            SRL, SRA:  C = shift_oob ? '0 : (A >> B[4:0]);
            OR:        C = A | B;
            AND:       C = A & B;
            SUB:       C = A - B;
            default:   C = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    int unsigned idx;
    logic        found;

    // First requester found after last_grant, in wrap-around order, wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last_grant) + i) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin grant, one registered
// ALU stage, per-requester response handshake. Optional opcode checking and
// error counting are enabled by defining ALU_SHARE_OPCHECK_EN.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0][W-1:0] req_a,
    input  logic [N_REQ-1:0][W-1:0] req_b,
    input  logic [N_REQ-1:0][3:0]   req_op,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [W-1:0]            rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e     state, state_nx;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  cur_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [3:0]     op_op;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic [31:0]    alu_c;
    logic           accept;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_rr (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    ALU u_alu (
        .A     (op_a),
        .B     (op_b),
        .alu_op(op_op),
        .C     (alu_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = grant;
                accept    = |req_valid;
                if (accept) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid[cur_id] = 1'b1;
                if (rsp_ready[cur_id]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on acceptance, result capture leaving EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IW'(N_REQ - 1);
            cur_id     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_op      <= '0;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                op_a       <= req_a[grant_idx];
                op_b       <= req_b[grant_idx];
                op_op      <= req_op[grant_idx];
                cur_id     <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == EXEC) rsp_data <= alu_c;
        end
    end

`ifdef ALU_SHARE_OPCHECK_EN
    logic [7:0] err_cnt;

    // Illegal-opcode flag and saturating error count, updated leaving EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
            err_cnt <= '0;
        end else if (state == EXEC) begin
            rsp_err <= is_illegal_op(op_op);
            if (is_illegal_op(op_op) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (N_REQ=2, W=32).
module tb_alu_share_arbiter;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][31:0] req_a;
    logic [N-1:0][31:0] req_b;
    logic [N-1:0][3:0]  req_op;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned r;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    alu_share_arbiter #(.N_REQ(N), .W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction on requester r with rsp_ready high; checks grant,
    // two-cycle latency to rsp_valid, result and error flag.
    task automatic run_op(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] exp, input string name);
        logic [N-1:0] onehot;
        logic         exp_err;
        bit           got;
        onehot = N'(1) << r;
`ifdef ALU_SHARE_OPCHECK_EN
        exp_err = (op >= 4'd10);
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        req_a[r]     = a;
        req_b[r]     = b;
        req_op[r]    = op;
        req_valid[r] = 1'b1;
        rsp_ready    = '1;
        #1;
        got = 0;
        for (int c = 0; c < 16; c++) begin
            if (req_ready[r]) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s grant timeout: req_ready=%b", name, req_ready);
        end
        chk({name, " req_ready"}, 32'(req_ready), 32'(onehot));
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        chk({name, " exec busy"}, 32'(busy), 32'd1);
        chk({name, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'(onehot));
        chk({name, " rsp_data"}, rsp_data, exp);
        chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g1;
`ifdef ALU_SHARE_OPCHECK_EN
        logic [7:0] cnt_before;
`endif
        vecs[0]  = '{0, 32'd5,        32'd3,        4'd0,  32'd8};
        vecs[1]  = '{0, 32'hFFFFFFFF, 32'd1,        4'd0,  32'd0};
        vecs[2]  = '{1, 32'd1,        32'd32,       4'd1,  32'd0};
        vecs[3]  = '{0, 32'h80000000, 32'd4,        4'd6,  32'h08000000};
        vecs[4]  = '{1, 32'hFFFFFFFF, 32'd1,        4'd3,  32'd0};
        vecs[5]  = '{0, 32'd3,        32'd5,        4'd2,  32'd1};
        vecs[6]  = '{1, 32'd1,        32'd4,        4'd1,  32'd16};
        vecs[7]  = '{0, 32'h80000000, 32'd31,       4'd5,  32'd1};
        vecs[8]  = '{1, 32'h0000FFFF, 32'd40,       4'd5,  32'd0};
        vecs[9]  = '{0, 32'h000000F0, 32'h0000000F, 4'd7,  32'h000000FF};
        vecs[10] = '{1, 32'h000000F0, 32'h0000003C, 4'd8,  32'h00000030};
        vecs[11] = '{0, 32'd3,        32'd5,        4'd9,  32'hFFFFFFFE};
        vecs[12] = '{1, 32'd7,        32'd7,        4'd12, 32'd0};
        vecs[13] = '{0, 32'd1,        32'd2,        4'd3,  32'd1};
        vecs[14] = '{1, 32'h0000F0F0, 32'h0000FF00, 4'd4,  32'h00000FF0};

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
`ifdef ALU_SHARE_OPCHECK_EN
        chk("reset err_cnt", 32'(dut.err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
`ifdef ALU_SHARE_OPCHECK_EN
            cnt_before = dut.err_cnt;
`endif
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
`ifdef ALU_SHARE_OPCHECK_EN
            chk($sformatf("vec%0d err_cnt", i), 32'(dut.err_cnt),
                (vecs[i].op >= 4'd10) ? 32'(cnt_before) + 32'd1 : 32'(cnt_before));
`endif
        end

        // Reset during EXEC: transaction dropped, grant pointer restored.
        run_op(0, 32'd2, 32'd2, 4'd0, 32'd4, "pre-reset");
        @(negedge clk);
        req_a[0]     = 32'd9;
        req_b[0]     = 32'd9;
        req_op[0]    = 4'd0;
        req_valid[0] = 1'b1;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        chk("rst exec busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst no response", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;

        // Contention: both requesters hold valid; grants must alternate from 0.
        @(negedge clk);
        for (int r = 0; r < N; r++) begin
            req_a[r]  = 32'd10;
            req_b[r]  = 32'd3;
            req_op[r] = 4'd9;
        end
        req_valid = '1;
        rsp_ready = '1;
        #1;
        for (int k = 0; k < 4; k++) begin
            g1 = N'(1) << (k % 2);
            chk($sformatf("rr%0d req_ready", k), 32'(req_ready), 32'(g1));
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d exec rsp_valid", k), 32'(rsp_valid), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 32'(g1));
            chk($sformatf("rr%0d rsp_data", k), rsp_data, 32'd7);
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        #1;

        // Backpressure: requester 0 holds off; requester 1's ready is ignored.
        @(negedge clk);
        req_a[0]     = 32'd1;
        req_b[0]     = 32'd2;
        req_op[0]    = 4'd0;
        req_valid[0] = 1'b1;
        rsp_ready    = 2'b10;
        #1;
        chk("bp req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_a[1]     = 32'd4;
        req_b[1]     = 32'd4;
        req_op[1]    = 4'd0;
        req_valid[1] = 1'b1;
        #1;
        chk("bp exec req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_data", c), rsp_data, 32'd3);
            chk($sformatf("bp%0d busy", c), 32'(busy), 32'd1);
            chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        chk("bp release busy", 32'(busy), 32'd0);
        chk("bp release req_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        @(negedge clk);
        #1;
        chk("bp next rsp_valid", 32'(rsp_valid), 32'd2);
        chk("bp next rsp_data", rsp_data, 32'd8);
        rsp_ready = '1;

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
